// File: rtl/peaks_pkg.sv
// -----------------------------------------------------------------------------
// peaks_pkg
// Shared sizes, types and FSM encoding for the peak selector and its
// compare/shift insertion network.
// -----------------------------------------------------------------------------
package peaks_pkg;

    localparam int N_FREQS          = 256;
    localparam int N_PEAKS          = 8;
    localparam int INPUT_AMPL_WIDTH = 24;
    localparam int FINAL_AMPL_WIDTH = 16;
    localparam int FREQ_WIDTH       = 8;

    typedef logic [INPUT_AMPL_WIDTH-1:0] ampl_t;
    typedef logic [FINAL_AMPL_WIDTH-1:0] final_ampl_t;
    typedef logic [FREQ_WIDTH-1:0]       freq_t;

    typedef struct packed {
        ampl_t ampl;
        freq_t freq;
    } peak_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } sel_state_t;

endpackage

// File: rtl/peak_list_insert.sv
// -----------------------------------------------------------------------------
// peak_list_insert
// Combinational shift-insert of one candidate into a list sorted by
// descending amplitude. Equal amplitudes keep the existing entry ahead.
//
// Ports:
//   list_i        current sorted list, slot 0 largest
//   count_i       number of occupied slots
//   cand_valid_i  candidate present this cycle
//   cand_i        candidate entry (amplitude + bin index)
//   list_o        list after insertion
//   count_o       occupied slots after insertion
// -----------------------------------------------------------------------------
module peak_list_insert
    import peaks_pkg::*;
#(
    parameter int PEAKS = N_PEAKS,
    parameter int CW    = $clog2(PEAKS + 1)
) (
    input  peak_entry_t [PEAKS-1:0] list_i,
    input  logic        [CW-1:0]    count_i,
    input  logic                    cand_valid_i,
    input  peak_entry_t             cand_i,
    output peak_entry_t [PEAKS-1:0] list_o,
    output logic        [CW-1:0]    count_o
);

    localparam logic [CW-1:0] FULL = CW'(PEAKS);

    // ahead[i]: slot i is occupied and stays in front of the candidate.
    // Because the list is sorted this is a thermometer code.
    logic [PEAKS-1:0] ahead;
    logic             full;
    logic             do_ins;

    always_comb begin
        ahead = '0;
        for (int i = 0; i < PEAKS; i++) begin
            ahead[i] = (CW'(i) < count_i) && (list_i[i].ampl >= cand_i.ampl);
        end
    end

    assign full   = (count_i == FULL);
    // When full, the candidate only enters by strictly beating the last slot.
    assign do_ins = cand_valid_i && (!full || !ahead[PEAKS-1]);

    always_comb begin
        list_o  = list_i;
        count_o = count_i;
        if (do_ins) begin
            list_o[0] = ahead[0] ? list_i[0] : cand_i;
            for (int i = 1; i < PEAKS; i++) begin
                if (ahead[i])
                    list_o[i] = list_i[i];
                else if (ahead[i-1])
                    list_o[i] = cand_i;
                else
                    list_o[i] = list_i[i-1];
            end
            if (!full)
                count_o = count_i + 1'b1;
        end
    end

endmodule

// File: rtl/peak_selector.sv
// -----------------------------------------------------------------------------
// peak_selector
// Scans one captured frame bin by bin and keeps the PEAKS largest flagged
// bins sorted by descending amplitude; publishes a registered peak list.
//
// Ports:
//   CLOCK_50     system clock
//   reset        synchronous, active-high reset
//   frame_valid  one-cycle pulse, is_peak/ampl_in hold a complete frame
//   is_peak      per-bin peak flags
//   ampl_in      per-bin amplitudes
//   busy         frame being scanned (SCAN and DONE)
//   out_valid    one-cycle pulse, new peak list on amplitudes/freqs
//   amplitudes   MSB-truncated peak amplitudes, slot 0 largest
//   freqs        bin index per slot
//   peak_count   number of valid slots
//   overrun      sticky, a frame arrived while busy and was dropped
//   min_thresh   (only with PEAK_MIN_THRESH_EN) minimum candidate amplitude
//
// Build option: define PEAK_MIN_THRESH_EN to add the min_thresh input.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for frame_valid; outputs hold the last list
// SCAN  | one bin per cycle through the shift-insert network
// DONE  | publish working list, pulse out_valid, back to IDLE
// -----------------------------------------------------------------------------
module peak_selector
    import peaks_pkg::*;
#(
    parameter int FREQS = N_FREQS,
    parameter int PEAKS = N_PEAKS,
    parameter int CW    = $clog2(PEAKS + 1)
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          frame_valid,
    input  logic        [FREQS-1:0]       is_peak,
    input  ampl_t       [FREQS-1:0]       ampl_in,
    output logic                          busy,
    output logic                          out_valid,
    output final_ampl_t [PEAKS-1:0]       amplitudes,
    output freq_t       [PEAKS-1:0]       freqs,
    output logic        [CW-1:0]          peak_count,
    output logic                          overrun
`ifdef PEAK_MIN_THRESH_EN
    ,
    input  ampl_t                         min_thresh
`endif
);

    localparam int IDX_W = (FREQS > 1) ? $clog2(FREQS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FREQS - 1);

    sel_state_t                state_q, state_d;
    logic        [IDX_W-1:0]   idx_q, idx_d;
    logic        [FREQS-1:0]   is_peak_q, is_peak_d;
    ampl_t       [FREQS-1:0]   ampl_q, ampl_d;
    peak_entry_t [PEAKS-1:0]   list_q, list_d;
    logic        [CW-1:0]      count_q, count_d;
    logic                      busy_q, busy_d;
    logic                      out_valid_q, out_valid_d;
    logic                      overrun_q, overrun_d;
    final_ampl_t [PEAKS-1:0]   amp_out_q, amp_out_d;
    freq_t       [PEAKS-1:0]   freq_out_q, freq_out_d;
    logic        [CW-1:0]      pcnt_q, pcnt_d;
`ifdef PEAK_MIN_THRESH_EN
    ampl_t                     thresh_q, thresh_d;
`endif

    peak_entry_t               cand;
    logic                      cand_valid;
    peak_entry_t [PEAKS-1:0]   ins_list;
    logic        [CW-1:0]      ins_count;

    assign cand.ampl = ampl_q[idx_q];
    assign cand.freq = freq_t'(idx_q);
`ifdef PEAK_MIN_THRESH_EN
    assign cand_valid = is_peak_q[idx_q] && (ampl_q[idx_q] >= thresh_q);
`else
    assign cand_valid = is_peak_q[idx_q];
`endif

    peak_list_insert #(
        .PEAKS (PEAKS),
        .CW    (CW)
    ) u_insert (
        .list_i       (list_q),
        .count_i      (count_q),
        .cand_valid_i (cand_valid),
        .cand_i       (cand),
        .list_o       (ins_list),
        .count_o      (ins_count)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        is_peak_d   = is_peak_q;
        ampl_d      = ampl_q;
        list_d      = list_q;
        count_d     = count_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        amp_out_d   = amp_out_q;
        freq_out_d  = freq_out_q;
        pcnt_d      = pcnt_q;
`ifdef PEAK_MIN_THRESH_EN
        thresh_d    = thresh_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    is_peak_d = is_peak;
                    ampl_d    = ampl_in;
`ifdef PEAK_MIN_THRESH_EN
                    thresh_d  = min_thresh;
`endif
                    list_d    = '0;
                    count_d   = '0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (frame_valid)
                    overrun_d = 1'b1;
                list_d  = ins_list;
                count_d = ins_count;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX)
                    state_d = DONE;
            end
            DONE: begin
                if (frame_valid)
                    overrun_d = 1'b1;
                for (int i = 0; i < PEAKS; i++) begin
                    if (CW'(i) < count_q) begin
                        amp_out_d[i]  = list_q[i].ampl[INPUT_AMPL_WIDTH-1 -: FINAL_AMPL_WIDTH];
                        freq_out_d[i] = list_q[i].freq;
                    end else begin
                        amp_out_d[i]  = '0;
                        freq_out_d[i] = '0;
                    end
                end
                pcnt_d      = count_q;
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            is_peak_q   <= '0;
            ampl_q      <= '0;
            list_q      <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            amp_out_q   <= '0;
            freq_out_q  <= '0;
            pcnt_q      <= '0;
`ifdef PEAK_MIN_THRESH_EN
            thresh_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            is_peak_q   <= is_peak_d;
            ampl_q      <= ampl_d;
            list_q      <= list_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            amp_out_q   <= amp_out_d;
            freq_out_q  <= freq_out_d;
            pcnt_q      <= pcnt_d;
`ifdef PEAK_MIN_THRESH_EN
            thresh_q    <= thresh_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
    assign amplitudes = amp_out_q;
    assign freqs      = freq_out_q;
    assign peak_count = pcnt_q;

endmodule

// File: tb/tb_peak_selector.sv
// -----------------------------------------------------------------------------
// tb_peak_selector
// Directed-vector bench for peak_selector with FREQS=16, PEAKS=4.
// Expected lists are hand-derived; reported amplitude = ampl[23:8].
// -----------------------------------------------------------------------------
module tb_peak_selector;

    localparam int FREQS = 16;
    localparam int PEAKS = 4;
    localparam int CW    = 3;

    logic                   clk;
    logic                   reset;
    logic                   frame_valid;
    logic [FREQS-1:0]       is_peak;
    logic [FREQS-1:0][23:0] ampl_in;
    logic                   busy;
    logic                   out_valid;
    logic [PEAKS-1:0][15:0] amplitudes;
    logic [PEAKS-1:0][7:0]  freqs;
    logic [CW-1:0]          peak_count;
    logic                   overrun;
`ifdef PEAK_MIN_THRESH_EN
    logic [23:0]            min_thresh;
`endif

    int n_checks = 0;
    int n_errors = 0;

    peak_selector #(
        .FREQS (FREQS),
        .PEAKS (PEAKS)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .is_peak     (is_peak),
        .ampl_in     (ampl_in),
        .busy        (busy),
        .out_valid   (out_valid),
        .amplitudes  (amplitudes),
        .freqs       (freqs),
        .peak_count  (peak_count),
        .overrun     (overrun)
`ifdef PEAK_MIN_THRESH_EN
        ,
        .min_thresh  (min_thresh)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slot 0 is the rightmost field of each concatenation argument.
    task automatic check_list(input string tag, input logic [3:0][7:0] ef,
                              input logic [3:0][15:0] ea, input logic [2:0] ec);
        check($sformatf("%s_count", tag), 64'(peak_count), 64'(ec));
        for (int i = 0; i < PEAKS; i++) begin
            check($sformatf("%s_freq%0d", tag, i), 64'(freqs[i]), 64'(ef[i]));
            check($sformatf("%s_ampl%0d", tag, i), 64'(amplitudes[i]), 64'(ea[i]));
        end
    endtask

    // Frame 1: bins 2,5,9 flagged; unflagged bins are loud so ignoring
    // the flags would be visible in the result.
    task automatic load_s1();
        is_peak = '0;
        for (int i = 0; i < FREQS; i++) ampl_in[i] = 24'h7F0000;
        is_peak[2] = 1'b1; ampl_in[2] = 24'h000300;
        is_peak[5] = 1'b1; ampl_in[5] = 24'h000900;
        is_peak[9] = 1'b1; ampl_in[9] = 24'h000100;
    endtask

    // Pulse frame_valid now (caller sits 1 time unit after a rising edge),
    // corrupt the inputs so only the captured copy can produce the result,
    // optionally inject a second frame, and wait for out_valid.
    task automatic launch(input string tag, input int inject_at);
        int lat;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_ovalid_low"}, 64'(out_valid), 64'd0);
        is_peak = '1;
        for (int i = 0; i < FREQS; i++) ampl_in[i] = 24'hFFFF00 - 24'(i);
        lat = 0;
        while (!out_valid && lat < 40) begin
            frame_valid = (lat == inject_at);
            @(posedge clk); #1;
            lat++;
        end
        frame_valid = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'd17);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int seen;
        reset       = 1'b1;
        frame_valid = 1'b0;
        is_peak     = '0;
        ampl_in     = '0;
`ifdef PEAK_MIN_THRESH_EN
        min_thresh  = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovalid", 64'(out_valid), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_count", 64'(peak_count), 64'd0);
        check("rst_ampls", 64'(amplitudes), 64'd0);
        check("rst_freqs", 64'(freqs), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Three flagged bins -> {5,2,9,-}, ampl[23:8] = {9,3,1,0}
        load_s1();
        launch("s1", -1);
        check_list("s1", {8'd0, 8'd9, 8'd2, 8'd5},
                   {16'h0000, 16'h0001, 16'h0003, 16'h0009}, 3'd3);

        // Back-to-back: accepted in the cycle after out_valid.
        // All bins flagged, ampl = bin<<16 -> ampl[23:8] = bin<<8
        is_peak = '1;
        for (int i = 0; i < FREQS; i++) ampl_in[i] = 24'(i) << 16;
        launch("s2", -1);
        check_list("s2", {8'd12, 8'd13, 8'd14, 8'd15},
                   {16'h0C00, 16'h0D00, 16'h0E00, 16'h0F00}, 3'd4);

        // Equal amplitudes keep bin order.
        @(posedge clk); #1;
        is_peak = '0;
        for (int i = 0; i < FREQS; i++) ampl_in[i] = 24'h7FFFFF;
        is_peak[3]  = 1'b1; ampl_in[3]  = 24'h050000;
        is_peak[7]  = 1'b1; ampl_in[7]  = 24'h050000;
        is_peak[11] = 1'b1; ampl_in[11] = 24'h050000;
        launch("s3", -1);
        check_list("s3", {8'd0, 8'd11, 8'd7, 8'd3},
                   {16'h0000, 16'h0500, 16'h0500, 16'h0500}, 3'd3);

        // No flagged bins: still pulses, empty list.
        @(posedge clk); #1;
        is_peak = '0;
        for (int i = 0; i < FREQS; i++) ampl_in[i] = 24'h123456;
        launch("s4", -1);
        check_list("s4", '0, '0, 3'd0);
        check("s4_overrun", 64'(overrun), 64'd0);

        // Second frame_valid mid-scan is dropped and sets overrun.
        @(posedge clk); #1;
        load_s1();
        launch("s5", 5);
        check_list("s5", {8'd0, 8'd9, 8'd2, 8'd5},
                   {16'h0000, 16'h0001, 16'h0003, 16'h0009}, 3'd3);
        check("s5_overrun", 64'(overrun), 64'd1);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen++;
        end
        check("s5_no_second_frame", 64'(seen), 64'd0);
        check("s5_overrun_sticky", 64'(overrun), 64'd1);

        // Reset at cycle 8 of a scan aborts it.
        load_s1();
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("s6_busy", 64'(busy), 64'd0);
        check("s6_overrun", 64'(overrun), 64'd0);
        check("s6_count", 64'(peak_count), 64'd0);
        check("s6_ampls", 64'(amplitudes), 64'd0);
        check("s6_freqs", 64'(freqs), 64'd0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("s6_no_ovalid", 64'(seen), 64'd0);
        load_s1();
        launch("s6b", -1);
        check_list("s6b", {8'd0, 8'd9, 8'd2, 8'd5},
                   {16'h0000, 16'h0001, 16'h0003, 16'h0009}, 3'd3);

`ifdef PEAK_MIN_THRESH_EN
        // Threshold 0x000500 keeps only bin 5 (0x000900).
        @(posedge clk); #1;
        load_s1();
        min_thresh = 24'h000500;
        launch("s7", -1);
        check_list("s7", {8'd0, 8'd0, 8'd0, 8'd5},
                   {16'h0000, 16'h0000, 16'h0000, 16'h0009}, 3'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
